// File: rtl/tia_phase_pkg.sv
// Shared types and widths for the TIA two-phase strobe generator.
package tia_phase_pkg;

  localparam int PHASE_W = 3;
  localparam int COUNT_W = 8;

  typedef enum logic [PHASE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_P1   = 3'd1,
    ST_GAP1 = 3'd2,
    ST_P2   = 3'd3,
    ST_GAP2 = 3'd4
  } phase_t;

endpackage

// File: rtl/tia_phase_gen_if.sv
// Control and strobe bundle between the phase generator and its user.
interface tia_phase_gen_if;
  import tia_phase_pkg::*;

  logic               run;
  logic               resync;
  logic               s1;
  logic               s2;
  logic [PHASE_W-1:0] phase;
  logic               sync_ack;
  logic [COUNT_W-1:0] cyc_count;
  logic               busy;

  modport master (
    output run, resync,
    input  s1, s2, phase, sync_ack, cyc_count, busy
  );

  modport slave (
    input  run, resync,
    output s1, s2, phase, sync_ack, cyc_count, busy
  );

endinterface

// File: rtl/tia_phase_gen.sv
// Two-phase (s1/s2) strobe generator for the D1/D2 latch chains.
// Define TIA_PHASE_GAP_EN to insert GAP1 between P1 and P2 (period 4 instead of 3).
module tia_phase_gen
  import tia_phase_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  tia_phase_gen_if.slave  bus
);

  phase_t             state;
  phase_t             next_state;
  logic               s1_q;
  logic               s2_q;
  logic               sync_ack_q;
  logic               busy_q;
  logic [COUNT_W-1:0] cyc_count_q;

  // Resync wins over the normal sequence in every state except IDLE.
  always_comb begin
    next_state = state;
    if (state != ST_IDLE && bus.resync) begin
      next_state = ST_GAP2;
    end else begin
      case (state)
        ST_IDLE: next_state = bus.run ? ST_P1 : ST_IDLE;
`ifdef TIA_PHASE_GAP_EN
        ST_P1:   next_state = ST_GAP1;
`else
        ST_P1:   next_state = ST_P2;
`endif
        ST_GAP1: next_state = ST_P2;
        ST_P2:   next_state = ST_GAP2;
        ST_GAP2: next_state = bus.run ? ST_P1 : ST_IDLE;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      sync_ack_q  <= 1'b0;
      busy_q      <= 1'b0;
      cyc_count_q <= '0;
    end else begin
      state      <= next_state;
      s1_q       <= (next_state == ST_P1);
      s2_q       <= (next_state == ST_P2);
      busy_q     <= (next_state != ST_IDLE);
      sync_ack_q <= (state != ST_IDLE) && bus.resync;
      if (state == ST_P2) begin
        cyc_count_q <= cyc_count_q + COUNT_W'(1);
      end
    end
  end

  assign bus.phase     = state;
  assign bus.s1        = s1_q;
  assign bus.s2        = s2_q;
  assign bus.sync_ack  = sync_ack_q;
  assign bus.busy      = busy_q;
  assign bus.cyc_count = cyc_count_q;

endmodule

// File: tb/tb_tia_phase_gen.sv
// Randomised self-checking bench for tia_phase_gen against a cycle-position reference model.
module tb_tia_phase_gen;
  import tia_phase_pkg::*;

`ifdef TIA_PHASE_GAP_EN
  localparam int PERIOD = 4;
`else
  localparam int PERIOD = 3;
`endif

  logic clk = 1'b0;
  logic reset_n;

  tia_phase_gen_if bus ();

  tia_phase_gen dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model: m_pos = -1 when idle, otherwise position 0..PERIOD-1 within the strobe cycle.
  int m_pos   = -1;
  int m_count = 0;
  bit m_ack   = 1'b0;
  bit pending = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  function automatic logic [14:0] expectedVec();
    logic [2:0] ph;
    if (m_pos < 0)                ph = 3'd0;
    else if (m_pos == 0)          ph = 3'd1;
    else if (m_pos == PERIOD - 1) ph = 3'd4;
    else if (m_pos == PERIOD - 2) ph = 3'd3;
    else                          ph = 3'd2;
    return {(m_pos == 0), (m_pos == PERIOD - 2), ph, m_ack, (m_pos >= 0), 8'(m_count % 256)};
  endfunction

  task automatic modelStep(input bit r, input bit rs, input bit rn);
    if (!rn) begin
      m_pos = -1; m_count = 0; m_ack = 1'b0;
    end else if (m_pos < 0) begin
      m_ack = 1'b0;
      m_pos = r ? 0 : -1;
    end else begin
      if (m_pos == PERIOD - 2) m_count = (m_count + 1) % 256;
      m_ack = rs;
      if (rs)                       m_pos = PERIOD - 1;
      else if (m_pos == PERIOD - 1) m_pos = r ? 0 : -1;
      else                          m_pos = m_pos + 1;
    end
  endtask

  // One clock: drive, let the edge happen, step the model, then compare everything.
  task automatic applyStimulus(input bit r, input bit rs, input bit rn, input string tag);
    bus.run    = r;
    bus.resync = rs;
    reset_n    = rn;
    @(posedge clk);
    modelStep(r, rs, rn);
    #1;
    checkOutput(tag, {17'd0, bus.s1, bus.s2, bus.phase, bus.sync_ack, bus.busy, bus.cyc_count},
                {17'd0, expectedVec()});
    if (bus.s1 && bus.s2) checkOutput("s1_s2_overlap", 1, 0);
    if (!rn || bus.sync_ack) pending = 1'b0;
    if (bus.s2) begin
      checkOutput("s2_without_s1", 32'(pending), 1);
      pending = 1'b0;
    end
    if (bus.s1) pending = 1'b1;
  endtask

  task automatic reachP1(input string tag);
    for (int i = 0; i < 8 && bus.phase != 3'd1; i++) applyStimulus(1, 0, 1, tag);
    checkOutput({tag, "_reach_p1"}, 32'(bus.phase), 1);
  endtask

  initial begin
    int snap;
    bus.run    = 1'b0;
    bus.resync = 1'b0;
    reset_n    = 1'b0;

    applyStimulus(1, 1, 0, "reset");
    applyStimulus(0, 0, 0, "reset_hold");
    checkOutput("reset_busy", 32'(bus.busy), 0);

    // Twelve clocks of run from idle.
    applyStimulus(1, 0, 1, "run_first");
    checkOutput("first_s1", 32'(bus.s1), 1);
    for (int i = 2; i <= 12; i++) applyStimulus(1, 0, 1, "run12");
    checkOutput("run12_count", 32'(bus.cyc_count), (PERIOD == 4) ? 3 : 4);

    // Resync in IDLE is ignored.
    for (int i = 0; i < PERIOD; i++) applyStimulus(0, 0, 1, "drain");
    applyStimulus(0, 1, 1, "idle_resync");
    checkOutput("idle_resync_ack", 32'(bus.sync_ack), 0);

    // Drop run while in P1: cycle still completes with one s2.
    reachP1("drop");
    snap = m_count;
    for (int i = 0; i < PERIOD - 2; i++) applyStimulus(0, 0, 1, "drop_run");
    checkOutput("drop_s2", 32'(bus.s2), 1);
    applyStimulus(0, 0, 1, "drop_gap2");
    applyStimulus(0, 0, 1, "drop_idle");
    checkOutput("drop_busy", 32'(bus.busy), 0);
    checkOutput("drop_count", 32'(bus.cyc_count), 32'((snap + 1) % 256));

    // Resync before P2 truncates the cycle without counting it.
    reachP1("rs");
    snap = m_count;
    for (int i = 0; i < PERIOD - 3; i++) applyStimulus(1, 0, 1, "rs_to_gap1");
    applyStimulus(1, 1, 1, "rs_pulse");
    checkOutput("rs_phase", 32'(bus.phase), 4);
    checkOutput("rs_ack", 32'(bus.sync_ack), 1);
    checkOutput("rs_no_s2", 32'(bus.s2), 0);
    applyStimulus(1, 1, 1, "rs_hold");
    checkOutput("rs_hold_ack", 32'(bus.sync_ack), 1);
    applyStimulus(1, 0, 1, "rs_resume");
    checkOutput("rs_resume_s1", 32'(bus.s1), 1);
    checkOutput("rs_count", 32'(bus.cyc_count), 32'(snap));

    // Resync and run falling together: GAP2 then IDLE.
    applyStimulus(0, 1, 1, "rs_run_fall");
    applyStimulus(0, 0, 1, "rs_run_idle");
    checkOutput("rs_run_idle_phase", 32'(bus.phase), 0);

    // Long run from reset exercises counter wrap.
    applyStimulus(0, 0, 0, "wrap_reset");
    for (int i = 0; i < 1024; i++) applyStimulus(1, 0, 1, "wrap");
    if (PERIOD == 4) checkOutput("wrap_count", 32'(bus.cyc_count), 0);

    // Random run/resync/reset traffic.
    for (int i = 0; i < 10000; i++)
      applyStimulus(($urandom_range(3) != 0), ($urandom_range(9) == 0),
                    ($urandom_range(99) != 0), "random");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
